// File: rtl/fusion_unit.sv
// Bit-Fusion style fused multiply-accumulate PE: per-lane w_j * sum(a_k) added to
// packed partial sums, with run-time 1/2/4/8-bit element widths and a 1-cycle register.
module fusion_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in,
  input  logic [7:0]  weight,
  input  logic [3:0]  in_width,
  input  logic [3:0]  weight_width,
  input  logic        s_in,
  input  logic        s_weight,
  input  logic [51:0] psum_in,
  output logic [51:0] psum_fwd
);

  localparam logic [1:0] W1 = 2'd0;
  localparam logic [1:0] W2 = 2'd1;
  localparam logic [1:0] W4 = 2'd2;
  localparam logic [1:0] W8 = 2'd3;

  function automatic logic [1:0] decode_width(input logic [3:0] w);
    case (w)
      4'd1:    return W1;
      4'd2:    return W2;
      4'd4:    return W4;
      default: return W8;
    endcase
  endfunction

  function automatic int bits_of(input logic [1:0] sel);
    case (sel)
      W1:      return 1;
      W2:      return 2;
      W4:      return 4;
      default: return 8;
    endcase
  endfunction

  // Element sits in raw's LSBs; 1-bit elements are always unsigned.
  function automatic logic signed [9:0] elem_ext(input logic [7:0] raw,
                                                 input logic [1:0] sel,
                                                 input logic       sgn);
    case (sel)
      W1:      return $signed({9'b0, raw[0]});
      W2:      return $signed({{8{sgn & raw[1]}}, raw[1:0]});
      W4:      return $signed({{6{sgn & raw[3]}}, raw[3:0]});
      default: return $signed({{2{sgn & raw[7]}}, raw});
    endcase
  endfunction

  function automatic logic signed [19:0] sx20(input logic signed [9:0] v);
    return $signed({{10{v[9]}}, v});
  endfunction

  function automatic logic signed [12:0] sx13(input logic signed [9:0] v);
    return $signed({{3{v[9]}}, v});
  endfunction

  logic [1:0]         iw_sel;
  logic [1:0]         ww_sel;
  logic signed [9:0]  act_sum;
  logic signed [9:0]  w_elem [4];
  logic signed [19:0] prod_lo [2];
  logic signed [12:0] prod_hi [2];
  logic [51:0]        psum_fwd_d;
  logic [51:0]        psum_fwd_q;

  assign iw_sel = decode_width(in_width);
  assign ww_sel = decode_width(weight_width);

  // Elements past the word end shift in as zero, so fixed-count loops stay exact.
  always_comb begin
    act_sum = '0;
    for (int k = 0; k < 8; k++) begin
      act_sum = act_sum + elem_ext(in >> (k * bits_of(iw_sel)), iw_sel, s_in);
    end
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_elem[j] = elem_ext(weight >> (j * bits_of(ww_sel)), ww_sel, s_weight);
    end
  end

  // Lanes 2/3 only exist at 13 bits, so their products are formed at that width.
  always_comb begin
    prod_lo[0] = sx20(w_elem[0]) * sx20(act_sum);
    prod_lo[1] = sx20(w_elem[1]) * sx20(act_sum);
    prod_hi[0] = sx13(w_elem[2]) * sx13(act_sum);
    prod_hi[1] = sx13(w_elem[3]) * sx13(act_sum);
  end

  always_comb begin
    psum_fwd_d = '0;
    case (ww_sel)
      W8: psum_fwd_d = psum_in + {{32{prod_lo[0][19]}}, prod_lo[0]};
      W4: begin
        psum_fwd_d[25:0]  = psum_in[25:0]  + {{6{prod_lo[0][19]}}, prod_lo[0]};
        psum_fwd_d[51:26] = psum_in[51:26] + {{6{prod_lo[1][19]}}, prod_lo[1]};
      end
      default: begin
        psum_fwd_d[12:0]  = psum_in[12:0]  + prod_lo[0][12:0];
        psum_fwd_d[25:13] = psum_in[25:13] + prod_lo[1][12:0];
        psum_fwd_d[38:26] = psum_in[38:26] + prod_hi[0];
        psum_fwd_d[51:39] = psum_in[51:39] + prod_hi[1];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) psum_fwd_q <= '0;
    else        psum_fwd_q <= psum_fwd_d;
  end

  assign psum_fwd = psum_fwd_q;

endmodule

// File: tb/tb_fusion_unit.sv
// Bench for fusion_unit: integer reference model checked every cycle, plus
// hand-computed literal vectors for reset, sweeps, lanes, accumulation and signs.
module tb_fusion_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_r;
  logic [7:0]  w_r;
  logic [3:0]  iw_r;
  logic [3:0]  ww_r;
  logic        si_r;
  logic        sw_r;
  logic [51:0] ps_r;
  logic [51:0] psum_fwd;
  logic [51:0] ref_q;
  logic        run;
  int          total;
  int          passed;

  fusion_unit dut (
    .clk(clk), .rst_n(rst_n), .in(in_r), .weight(w_r),
    .in_width(iw_r), .weight_width(ww_r), .s_in(si_r), .s_weight(sw_r),
    .psum_in(ps_r), .psum_fwd(psum_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: split into elements, sum activations, then per-lane wrap-around MAC.
  function automatic logic [51:0] model(input logic [7:0] a, input logic [7:0] w,
                                        input logic [3:0] iw, input logic [3:0] ww,
                                        input logic sa, input logic sw,
                                        input logic [51:0] ps);
    int iwd, wwd, nl, lw;
    longint s, e, wj, lane, lmask, res;
    iwd = (iw == 4'd1 || iw == 4'd2 || iw == 4'd4) ? int'(iw) : 8;
    wwd = (ww == 4'd1 || ww == 4'd2 || ww == 4'd4) ? int'(ww) : 8;
    s = 0;
    for (int k = 0; k < 8 / iwd; k++) begin
      e = (longint'(a) >> (k * iwd)) & ((longint'(1) << iwd) - 1);
      if (sa && iwd > 1 && ((e >> (iwd - 1)) & 1) == 1) e = e - (longint'(1) << iwd);
      s = s + e;
    end
    nl = (wwd == 8) ? 1 : (wwd == 4) ? 2 : 4;
    lw = 52 / nl;
    lmask = (longint'(1) << lw) - 1;
    res = 0;
    for (int j = 0; j < nl; j++) begin
      wj = (longint'(w) >> (j * wwd)) & ((longint'(1) << wwd) - 1);
      if (sw && wwd > 1 && ((wj >> (wwd - 1)) & 1) == 1) wj = wj - (longint'(1) << wwd);
      lane = (longint'(ps) >> (j * lw)) & lmask;
      lane = (lane + wj * s) & lmask;
      res = res | (lane << (j * lw));
    end
    return res[51:0];
  endfunction

  task automatic chk(input string name, input logic [51:0] act, input logic [51:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_q <= '0;
    else        ref_q <= model(in_r, w_r, iw_r, ww_r, si_r, sw_r, ps_r);
  end

  always @(negedge clk) begin
    if (run) chk("model", psum_fwd, ref_q);
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] w, input logic [3:0] iw,
                       input logic [3:0] ww, input logic sa, input logic sw,
                       input logic [51:0] ps);
    @(negedge clk);
    in_r = a; w_r = w; iw_r = iw; ww_r = ww; si_r = sa; sw_r = sw; ps_r = ps;
    @(posedge clk);
    #1;
  endtask

  int pi [10] = '{1, 2, 4, 8, 2, 4, 4, 8, 8, 2};
  int pw [10] = '{1, 2, 4, 8, 4, 2, 8, 4, 2, 8};
  logic [3:0] wset [7] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd0, 4'd3, 4'd15};

  initial begin
    total = 0; passed = 0; run = 1'b1;
    rst_n = 1'b0;
    in_r = 8'hA5; w_r = 8'h5A; iw_r = 4'd8; ww_r = 4'd8; si_r = 1'b0; sw_r = 1'b0;
    ps_r = 52'h123;
    repeat (3) @(posedge clk);
    #1 chk("reset_hold", psum_fwd, 52'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hFF, 8'hFF, 4'd8, 4'd8, 1'b0, 1'b0, 52'd0);
    chk("first_after_reset", psum_fwd, 52'd65025);

    for (int p = 0; p < 10; p++) begin
      for (int a = 0; a < (1 << pi[p]); a += ((pi[p] == 8 && pw[p] == 8) ? 3 : 1)) begin
        for (int b = 0; b < (1 << pw[p]); b++) begin
          drive(8'(a), 8'(b), 4'(pi[p]), 4'(pw[p]), 1'b0, 1'b0, 52'd0);
          chk($sformatf("sweep_%0dx%0d_%0d_%0d", pi[p], pw[p], a, b),
              psum_fwd, 52'(a * b));
        end
      end
    end
    drive(8'h0F, 8'hFF, 4'd4, 4'd8, 1'b0, 1'b0, 52'd0);
    chk("sweep_4x8_15_255", psum_fwd, 52'd3825);

    drive(8'hE4, 8'hE4, 4'd2, 4'd2, 1'b0, 1'b0, 52'd0);
    chk("lanes_2x2", psum_fwd, {13'd18, 13'd12, 13'd6, 13'd0});

    drive(8'hD4, 8'hE4, 4'd4, 4'd2, 1'b0, 1'b0, 52'd0);
    chk("chain_step1", psum_fwd, {13'd51, 13'd34, 13'd17, 13'd0});
    drive(8'h89, 8'hE4, 4'd8, 4'd2, 1'b0, 1'b0, {13'd51, 13'd34, 13'd17, 13'd0});
    chk("chain_step2", psum_fwd, {13'd462, 13'd308, 13'd154, 13'd0});

    for (int a = -128; a <= -120; a++) begin
      for (int b = -128; b <= -120; b++) begin
        drive(8'(a), 8'(b), 4'd8, 4'd8, 1'b1, 1'b1, 52'd0);
        chk($sformatf("signed_%0d_%0d", a, b), psum_fwd, 52'(longint'(a) * longint'(b)));
      end
    end
    drive(8'h80, 8'h88, 4'd8, 4'd8, 1'b1, 1'b1, 52'd0);
    chk("signed_80x88", psum_fwd, 52'd15360);

    drive(8'h80, 8'h02, 4'd8, 4'd8, 1'b1, 1'b0, 52'd0);
    chk("mixed_sign", psum_fwd, 52'hFFFFFFFFFFF00);

    // 4x4 signed: S = 7 + (-1) = 6, w = {3, -2}
    drive(8'hF7, 8'h3E, 4'd4, 4'd4, 1'b1, 1'b1, 52'd0);
    chk("signed_4x4_lanes", psum_fwd, {26'd18, 26'h3FFFFF4});

    drive(8'd3, 8'd5, 4'd3, 4'd0, 1'b0, 1'b0, 52'd0);
    chk("width_decode", psum_fwd, 52'd15);

    // 1x1: S = popcount(0xFF) = 8, weight[7:4] ignored, lane 1 wraps from 0x1FFF
    drive(8'hFF, 8'hF3, 4'd1, 4'd1, 1'b1, 1'b1, {13'd0, 13'd0, 13'h1FFF, 13'd0});
    chk("wrap_1x1", psum_fwd, {13'd0, 13'd0, 13'd7, 13'd8});

    for (int r = 0; r < 400; r++) begin
      drive(8'($urandom), 8'($urandom), wset[$urandom_range(0, 6)],
            wset[$urandom_range(0, 6)], 1'($urandom), 1'($urandom),
            {20'($urandom), 32'($urandom)});
    end

    drive(8'hFF, 8'h7F, 4'd8, 4'd8, 1'b0, 1'b0, 52'd0);
    chk("pre_async", psum_fwd, 52'd32385);
    #2 rst_n = 1'b0;
    #1 chk("async_clear", psum_fwd, 52'd0);
    @(posedge clk);
    #1 chk("reset_discard", psum_fwd, 52'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'd10, 8'd20, 4'd8, 4'd8, 1'b0, 1'b0, 52'd7);
    chk("after_async", psum_fwd, 52'd207);

    @(negedge clk);
    run = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fusion_unit.md
Name: fusion_unit

Overview:
Bit-level fused multiply-accumulate processing element for a Bit-Fusion-style systolic array. It multiplies an 8-bit activation word (`in`) by an 8-bit weight word (`weight`), each split into elements of a run-time width (1/2/4/8 bits). It adds the resulting per-lane products to an incoming partial sum and forwards the registered result to the next PE.

Parameters:
- None. All widths are fixed: 8-bit operands, 52-bit partial sum.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in  input  8  activation word, packed elements, element 0 in the LSBs
- weight  input  8  weight word, packed elements, element 0 in the LSBs
- in_width  input  4  activation element width: 1, 2, 4 or 8
- weight_width  input  4  weight element width: 1, 2, 4 or 8
- s_in  input  1  1 = activation elements are two's-complement signed
- s_weight  input  1  1 = weight elements are two's-complement signed
- psum_in  input  52  incoming packed partial sums
- psum_fwd  output  52  registered packed partial sums to the next PE

Behaviour:
- Reset: rst_n low asynchronously forces psum_fwd = 0; it stays 0 until the first rising edge after rst_n goes high.
- Latency: 1 cycle. psum_fwd at each rising edge captures the function of in, weight, widths, sign flags and psum_in as sampled at that edge. No handshake; a new operation is accepted every cycle.
- Width decode: any width value other than 1, 2 or 4 is treated as 8.
- Activation reduction S: split `in` into 8/in_width elements a_k, with a_k = in[k*in_width +: in_width].
  - Each a_k is sign-extended if s_in = 1, else zero-extended.
  - S = sum of all a_k.
  - For in_width = 1, elements are always unsigned; s_in is ignored.
- Lane layout by weight_width:
  - 8: one lane, 52 bits, psum[51:0].
  - 4: two lanes of 26 bits, psum[25:0] and psum[51:26].
  - 2 or 1: four lanes of 13 bits, lane j = psum[13j+12 : 13j].
- Weight elements:
  - weight_width 8/4/2: w_j = weight[j*ww +: ww], signed per s_weight.
  - weight_width 1: w_j = weight[j] for j = 0..3, always unsigned; weight[7:4] ignored.
- Lane result: lane_j(psum_fwd) = lane_j(psum_in) + w_j × S, computed as a full signed product and truncated (two's complement) to the lane width.
  - Overflow wraps within the lane; there is no carry or borrow between lanes.
- Implementation: 16 2b×2b BitBricks plus shift-add fusion trees is the intended structure. Any implementation meeting the arithmetic above is compliant.
- Reset asserted mid-operation: psum_fwd clears immediately; the in-flight result is discarded.

Test Plan:
- Reset: hold rst_n = 0 with nonzero inputs -> psum_fwd = 0. Release rst_n, then one edge with in = 255, weight = 255, widths 8/8, unsigned, psum_in = 0 -> psum_fwd = 65025.
- Exhaustive unsigned sweeps over the width pairs (1,1), (2,2), (4,4), (8,8), (2,4), (4,2), (4,8), (8,4), (8,2), (2,8):
  - in and weight range over 0..2^width-1, psum_in = 0.
  - Required: psum_fwd = in × weight one cycle later (e.g. 4×8, in = 15, weight = 255 -> 3825).
- 2×2 unsigned, in = 0xE4, weight = 0xE4, psum_in = 0 -> lanes [12:0], [25:13], [38:26], [51:39] = 0, 6, 12, 18.
- Accumulation chain:
  - 4×2 unsigned, in = 0xD4, weight = 0xE4 -> lanes 0, 17, 34, 51.
  - Feed that result back as psum_in, set in_width = 8, in = 0x89, weight = 0xE4 -> lanes 0, 154, 308, 462.
- Signed 8×8 (s_in = s_weight = 1), in and weight swept over -128..-120 -> psum_fwd = product (e.g. 0x80 × 0x88 -> 15360).
- Mixed sign 8×8, s_in = 1, s_weight = 0, in = 0x80, weight = 0x02 -> psum_fwd = 52-bit two's complement of -256 = 0xFFFFFFFFFFF00.
